prim_group_queue: RTL and testbench
===================================

Name: prim_group_queue

Overview:
- Parametrised successor to the BVH primitive-group FIFO.
- Buffers primitive ranges pushed by BVH traversal, up to CH groups per push, in a DEPTH-entry circular queue.
- Walks each range in AABB-test-unit strides, presenting one query window per pop to the ray/AABB test units.
- Adds a ready/overflow back-pressure path, occupancy reporting, zero-bubble group chaining and an explicit traversal-done handshake.

Parameters:
IDX_W, 16, primitive index width
NUM_W, 8, primitive count width per group
CH, 2, groups accepted per push
DEPTH, 8, queue entries; power of 2, >= CH
UNIT_W, 2, log2 of AABB test unit size (UNIT = 2^UNIT_W); 0 is legal
GLOBAL_START, 240, first global primitive index (optional feature only)
GLOBAL_NUM, 3, global primitive count (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse: flush queue, begin new ray
push  in  1  enqueue request
push_start  in  CH*IDX_W  channel i at bits [i*IDX_W +: IDX_W]
push_num  in  CH*NUM_W  channel i count; 0 = channel unused
push_ready  out  1  queue has room for CH entries
trav_done  in  1  level: traversal issues no further pushes this ray
pop  in  1  consume current window
q_valid  out  1  window valid
q_start  out  IDX_W  window start index
q_end  out  IDX_W  aligned group end
q_real_end  out  IDX_W  unaligned group end (start+num)
occupancy  out  $clog2(DEPTH+1)  queued entries, excluding the active window
overflow  out  1  sticky: a push was dropped
done  out  1  ray finished

Behaviour:
- States: IDLE, RUN, DONE.
- Reset:
  - State IDLE; all outputs 0; push_ready=1.
  - Pointers and window registers cleared.
  - Reset overrides start, push and pop.
- start (any state):
  - Flush queue and window; clear overflow and done; go to RUN.
  - Same-cycle push is applied after the flush.
- push:
  - Ignored outside RUN and while start is low in IDLE; no overflow in that case.
  - In RUN, k = number of channels with num>0. These are enqueued in ascending channel order, all in one edge.
  - Accepted only if occupancy+k <= DEPTH. Otherwise the whole push is dropped (never partial) and overflow is set.
  - push_ready = (occupancy <= DEPTH-CH).
- Group load: the top entry loads into the window. cur_start=start, real_end=start+num, end=start+ceil(num/UNIT)*UNIT. All sums are modulo 2^IDX_W.
- q_valid = RUN && cur_start < end. Outputs are registered.
- Pop with q_valid: cur_start += UNIT.
  - If the new cur_start >= end and the queue is non-empty, the next group loads on the same edge (no bubble).
- Window exhausted, queue non-empty, no pop: load next group on the next edge.
  - Latency from push acceptance into an idle window to q_valid is 1 cycle.
- Pop with q_valid=0: ignored.
- Simultaneous push and load on one edge: occupancy = old + k − 1.
- Wrap-around: pointers are $clog2(DEPTH) bits plus 1 wrap bit. full/empty come from the pointers.
- Completion: in RUN with trav_done=1, window exhausted, queue empty and no push accepted this cycle, go to DONE next edge.
  - DONE: done=1, q_valid=0. Held until start or reset.
- reset mid-RUN: returns to IDLE per reset values; the pending window is discarded.

Optional Feature:
- Macro: PRIM_QUEUE_GLOBAL_GROUP_EN.
- Defined: start enqueues the group (GLOBAL_START, GLOBAL_NUM) as entry 0, ahead of any same-cycle push. It counts toward occupancy and capacity.
- Undefined: the queue is empty after start; GLOBAL_* are unused.

Test Plan:
- Feature off, UNIT=4: start; push ch0=(10,5), ch1=(0,0) → after 1 cycle q_valid=1, q_start=10, q_end=18, q_real_end=15; pop → q_start=14; pop → q_valid=0.
- Push ch0=(0,4), ch1=(20,8); pop every cycle → q_start 0, 20, 24 on consecutive cycles; occupancy 2→1→0.
- DEPTH=8: four 2-channel pushes with no pops → occupancy=8 (minus 1 load), push_ready=0; further push → overflow=1, occupancy unchanged, no entries lost.
- Queue holding 3 entries; start with a same-cycle push (50,2) → old entries gone, overflow=0, q_start=50, q_real_end=52.
- trav_done=1, final pop of last window → done=1 on next edge; later pop and push ignored; reset mid-RUN → all outputs 0, state IDLE.
- Feature on: start → q_start=240, q_end=244, q_real_end=243, occupancy=0 after load.

Source files
------------

// File: rtl/prim_group_queue.sv
// rtl/prim_group_queue.sv - BVH primitive-group queue walking ranges in AABB-unit query windows.
// Optional build macro PRIM_QUEUE_GLOBAL_GROUP_EN preloads the global primitive group on start.
module prim_group_queue #(
    parameter int IDX_W        = 16,
    parameter int NUM_W        = 8,
    parameter int CH           = 2,
    parameter int DEPTH        = 8,
    parameter int UNIT_W       = 2,
    parameter int GLOBAL_START = 240,
    parameter int GLOBAL_NUM   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       push,
    input  logic [CH*IDX_W-1:0]        push_start,
    input  logic [CH*NUM_W-1:0]        push_num,
    output logic                       push_ready,
    input  logic                       trav_done,
    input  logic                       pop,
    output logic                       q_valid,
    output logic [IDX_W-1:0]           q_start,
    output logic [IDX_W-1:0]           q_end,
    output logic [IDX_W-1:0]           q_real_end,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow,
    output logic                       done
);
    localparam int PW    = $clog2(DEPTH);
    localparam int PTR_W = PW + 1;
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int CW    = PW + 2;
    localparam int NW1   = NUM_W + 1;
    localparam int UNIT  = 1 << UNIT_W;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] mem_start_q [DEPTH];
    logic [IDX_W-1:0] mem_start_d [DEPTH];
    logic [NUM_W-1:0] mem_num_q [DEPTH];
    logic [NUM_W-1:0] mem_num_d [DEPTH];
    logic [IDX_W-1:0] cur_start_q, cur_start_d;
    logic [IDX_W-1:0] end_q, end_d;
    logic [IDX_W-1:0] real_end_q, real_end_d;
    logic             overflow_q, overflow_d;

    logic [PTR_W-1:0] base_wr, base_rd, slot;
    logic [CW-1:0]    base_occ, k, off;
    logic             push_en, push_ok, win_valid, pop_fire, exhausted, load;
    logic [IDX_W-1:0] next_cur, ld_start;
    logic [NUM_W-1:0] ld_num;
    logic [NW1-1:0]   rounded;

`ifndef PRIM_QUEUE_GLOBAL_GROUP_EN
    logic unused_global;
    assign unused_global = (GLOBAL_START != GLOBAL_NUM);
`endif

    assign win_valid  = (cur_start_q < end_q);
    assign q_valid    = (state_q == RUN) && win_valid;
    assign q_start    = cur_start_q;
    assign q_end      = end_q;
    assign q_real_end = real_end_q;
    assign occupancy  = OW'(wr_ptr_q - rd_ptr_q);
    assign push_ready = (CW'(occupancy) <= CW'(DEPTH - CH));
    assign overflow   = overflow_q;
    assign done       = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        mem_start_d = mem_start_q;
        mem_num_d   = mem_num_q;
        cur_start_d = cur_start_q;
        end_d       = end_q;
        real_end_d  = real_end_q;
        overflow_d  = overflow_q;
        base_wr     = wr_ptr_q;
        base_rd     = rd_ptr_q;
        slot        = '0;
        k           = '0;
        off         = '0;
        load        = 1'b0;
        ld_start    = '0;
        ld_num      = '0;
        rounded     = '0;
        pop_fire    = pop && q_valid;
        exhausted   = !win_valid;
        next_cur    = cur_start_q + IDX_W'(UNIT);

        // start flushes first so a same-cycle push lands in the fresh queue
        if (start) begin
            state_d     = RUN;
            overflow_d  = 1'b0;
            cur_start_d = '0;
            end_d       = '0;
            real_end_d  = '0;
            base_wr     = '0;
            base_rd     = '0;
`ifdef PRIM_QUEUE_GLOBAL_GROUP_EN
            mem_start_d[0] = IDX_W'(GLOBAL_START);
            mem_num_d[0]   = NUM_W'(GLOBAL_NUM);
            base_wr        = PTR_W'(1);
`endif
        end

        base_occ = CW'(base_wr - base_rd);
        push_en  = push && (start || (state_q == RUN));
        for (int i = 0; i < CH; i++) begin
            if (push_num[i*NUM_W +: NUM_W] != '0) k = k + CW'(1);
        end
        push_ok = push_en && (k != '0) && ((base_occ + k) <= CW'(DEPTH));
        if (push_en && (k != '0) && !push_ok) overflow_d = 1'b1;

        wr_ptr_d = base_wr;
        rd_ptr_d = base_rd;
        if (push_ok) begin
            for (int i = 0; i < CH; i++) begin
                if (push_num[i*NUM_W +: NUM_W] != '0) begin
                    slot = base_wr + PTR_W'(off);
                    mem_start_d[slot[PW-1:0]] = push_start[i*IDX_W +: IDX_W];
                    mem_num_d[slot[PW-1:0]]   = push_num[i*NUM_W +: NUM_W];
                    off = off + CW'(1);
                end
            end
            wr_ptr_d = base_wr + PTR_W'(k);
        end

        if ((state_q == RUN) && !start) begin
            if (pop_fire) cur_start_d = next_cur;
            // a pop that empties the window chains straight into the next group
            load = (rd_ptr_q != wr_ptr_q) && (exhausted || (pop_fire && !(next_cur < end_q)));
            if (load) begin
                ld_start    = mem_start_q[rd_ptr_q[PW-1:0]];
                ld_num      = mem_num_q[rd_ptr_q[PW-1:0]];
                rounded     = ((NW1'(ld_num) + NW1'(UNIT - 1)) >> UNIT_W) << UNIT_W;
                cur_start_d = ld_start;
                real_end_d  = ld_start + IDX_W'(ld_num);
                end_d       = ld_start + IDX_W'(rounded);
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            end
            if (trav_done && exhausted && (rd_ptr_q == wr_ptr_q) && !push_ok) state_d = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cur_start_q <= '0;
            end_q       <= '0;
            real_end_q  <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_start_q[i] <= '0;
                mem_num_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cur_start_q <= cur_start_d;
            end_q       <= end_d;
            real_end_q  <= real_end_d;
            overflow_q  <= overflow_d;
            mem_start_q <= mem_start_d;
            mem_num_q   <= mem_num_d;
        end
    end
endmodule

// File: tb/tb_prim_group_queue.sv
// tb/tb_prim_group_queue.sv - directed self-checking bench for prim_group_queue.
module tb_prim_group_queue;
    logic        clk = 1'b0;
    logic        reset, start, push, trav_done, pop;
    logic [31:0] push_start;
    logic [15:0] push_num;
    logic        push_ready, q_valid, overflow, done;
    logic [15:0] q_start, q_end, q_real_end;
    logic [3:0]  occupancy;
    int          total = 0;
    int          bad = 0;

    prim_group_queue dut (
        .clk(clk), .reset(reset), .start(start), .push(push),
        .push_start(push_start), .push_num(push_num), .push_ready(push_ready),
        .trav_done(trav_done), .pop(pop), .q_valid(q_valid), .q_start(q_start),
        .q_end(q_end), .q_real_end(q_real_end), .occupancy(occupancy),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_push(input logic [15:0] s0, input logic [7:0] n0,
                            input logic [15:0] s1, input logic [7:0] n1);
        push       = 1'b1;
        push_start = {s1, s0};
        push_num   = {n1, n0};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; push = 1'b0; trav_done = 1'b0; pop = 1'b0;
        push_start = '0; push_num = '0;
        tick(); tick();
        check("rst_q_valid", q_valid, 0);
        check("rst_q_start", q_start, 0);
        check("rst_q_end", q_end, 0);
        check("rst_q_real_end", q_real_end, 0);
        check("rst_occ", occupancy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        check("rst_push_ready", push_ready, 1);
        reset = 1'b0;

`ifdef PRIM_QUEUE_GLOBAL_GROUP_EN
        start = 1'b1; tick(); start = 1'b0;
        check("glb_occ_queued", occupancy, 1);
        check("glb_valid_pre", q_valid, 0);
        tick();
        check("glb_valid", q_valid, 1);
        check("glb_start", q_start, 240);
        check("glb_end", q_end, 244);
        check("glb_real_end", q_real_end, 243);
        check("glb_occ_loaded", occupancy, 0);
`else
        // push into an idle window: one cycle to load
        start = 1'b1; tick(); start = 1'b0;
        set_push(16'd10, 8'd5, 16'd0, 8'd0); tick(); push = 1'b0;
        check("t1_occ_after_push", occupancy, 1);
        check("t1_valid_pre", q_valid, 0);
        tick();
        check("t1_valid", q_valid, 1);
        check("t1_start", q_start, 10);
        check("t1_end", q_end, 18);
        check("t1_real_end", q_real_end, 15);
        check("t1_occ_loaded", occupancy, 0);
        pop = 1'b1; tick();
        check("t1_pop1_start", q_start, 14);
        check("t1_pop1_valid", q_valid, 1);
        tick(); pop = 1'b0;
        check("t1_pop2_valid", q_valid, 0);

        // two groups, pop every cycle, zero-bubble chaining
        set_push(16'd0, 8'd4, 16'd20, 8'd8); tick(); push = 1'b0;
        check("t2_occ2", occupancy, 2);
        pop = 1'b1; tick();
        check("t2_start0", q_start, 0);
        check("t2_end0", q_end, 4);
        check("t2_occ1", occupancy, 1);
        tick();
        check("t2_start20", q_start, 20);
        check("t2_valid20", q_valid, 1);
        check("t2_end20", q_end, 28);
        check("t2_real_end20", q_real_end, 28);
        check("t2_occ0", occupancy, 0);
        tick();
        check("t2_start24", q_start, 24);
        tick(); pop = 1'b0;
        check("t2_drained", q_valid, 0);

        // fill to capacity, then a dropped push
        for (int i = 0; i < 4; i++) begin
            set_push(16'(100 + 8 * i), 8'd4, 16'(104 + 8 * i), 8'd4);
            tick();
        end
        check("t3_occ7", occupancy, 7);
        check("t3_not_ready", push_ready, 0);
        check("t3_win_start", q_start, 100);
        check("t3_no_ovf_yet", overflow, 0);
        set_push(16'd200, 8'd4, 16'd204, 8'd4); tick(); push = 1'b0;
        check("t3_overflow", overflow, 1);
        check("t3_occ_unchanged", occupancy, 7);
        pop = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t3_drain_start", q_start, 32'(104 + 4 * i));
            check("t3_drain_valid", q_valid, 1);
        end
        tick(); pop = 1'b0;
        check("t3_drain_done", q_valid, 0);
        check("t3_drain_occ", occupancy, 0);

        // restart with entries queued and a same-cycle push
        set_push(16'd300, 8'd4, 16'd304, 8'd4); tick();
        set_push(16'd308, 8'd4, 16'd312, 8'd4); tick(); push = 1'b0;
        check("t4_occ3", occupancy, 3);
        start = 1'b1; set_push(16'd50, 8'd2, 16'd0, 8'd0); tick();
        start = 1'b0; push = 1'b0;
        check("t4_occ_flushed", occupancy, 1);
        check("t4_ovf_cleared", overflow, 0);
        tick();
        check("t4_valid", q_valid, 1);
        check("t4_start", q_start, 50);
        check("t4_real_end", q_real_end, 52);
        check("t4_end", q_end, 54);
        check("t4_occ0", occupancy, 0);

        // completion and ignored activity in DONE
        trav_done = 1'b1; pop = 1'b1; tick(); pop = 1'b0;
        check("t5_last_pop_valid", q_valid, 0);
        check("t5_not_done_yet", done, 0);
        tick();
        check("t5_done", done, 1);
        set_push(16'd60, 8'd4, 16'd0, 8'd0); pop = 1'b1; tick();
        push = 1'b0; pop = 1'b0;
        check("t5_done_held", done, 1);
        check("t5_push_ignored", occupancy, 0);
        check("t5_no_ovf", overflow, 0);
        check("t5_valid_low", q_valid, 0);

        // reset mid-run discards the window
        trav_done = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("t6_done_cleared", done, 0);
        set_push(16'd70, 8'd4, 16'd0, 8'd0); tick(); push = 1'b0;
        tick();
        check("t6_valid", q_valid, 1);
        check("t6_start", q_start, 70);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_rst_valid", q_valid, 0);
        check("t6_rst_start", q_start, 0);
        check("t6_rst_end", q_end, 0);
        check("t6_rst_real_end", q_real_end, 0);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_ready", push_ready, 1);

        // push in IDLE without start is ignored
        set_push(16'd80, 8'd4, 16'd84, 8'd4); tick(); push = 1'b0;
        tick();
        check("t7_idle_occ", occupancy, 0);
        check("t7_idle_valid", q_valid, 0);
        check("t7_idle_ovf", overflow, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
